// File: rtl/gcd_pkg.sv
// ============================================================================
// Module   : gcd_pkg
// Purpose  : Shared defaults and FSM state encoding for the GCD feeder.
// Contents : GCD_WIDTH   - default operand/result width
//            GCD_TIMEOUT - default RUN-cycle budget before abort
//            state_t     - feeder FSM states
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_CLEAR  = 3'd4,
    S_OUT    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gcd_feeder_if.sv
// ============================================================================
// Module   : gcd_feeder_if
// Purpose  : Upstream operand and downstream result handshake of gcd_feeder.
// Signals  : in_valid/in_ready/in_a/in_b     - operand pair stream
//            out_valid/out_ready/out_gcd/out_err - result stream
// Modports : master - environment side, slave - feeder side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gcd_feeder_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gcd, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gcd, out_err
  );

endinterface

`default_nettype wire

// File: rtl/gcd_timeout_counter.sv
// ============================================================================
// Module   : gcd_timeout_counter
// Purpose  : RUN-cycle counter with terminal-count flag at TIMEOUT-1.
// Ports    : clk     - clock
//            rst_n   - synchronous active-low reset
//            i_clear - synchronous clear to zero
//            i_en    - count enable
//            o_tc    - count equals TIMEOUT-1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_tc = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Saturates at the terminal value so the flag cannot wrap away.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == c_tc);

endmodule

`default_nettype wire

// File: rtl/gcd_feeder.sv
// ============================================================================
// Module   : gcd_feeder
// Purpose  : Accepts an operand pair, feeds it serially to an external GCD
//            core, supervises it with a timeout and presents the result.
//            Zero operands bypass the core.
// Ports    : clk, rst_n     - clock, synchronous active-low reset
//            bus (slave)    - operand/result handshakes
//            core_data_in   - shared operand bus to the core
//            core_start     - start pulse (with operand a)
//            core_done      - core finished
//            core_result    - core result
//            core_rst_n     - active-low clear to the core
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_feeder
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_feeder_if.slave      bus,
  output logic [WIDTH-1:0] core_data_in,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             core_rst_n
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_gcd;
  logic             r_err;
  logic             w_in_ready;
  logic             w_start;
  logic [WIDTH-1:0] w_data;
  logic             w_tc;
  logic             w_a_zero;
  logic             w_b_zero;

  assign w_a_zero = (bus.in_a == '0);
  assign w_b_zero = (bus.in_b == '0);

  gcd_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (r_state != S_RUN),
    .i_en    (r_state == S_RUN),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_start    = 1'b0;
    w_data     = '0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = (w_a_zero || w_b_zero) ? S_OUT : S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        w_start = 1'b1;
        w_data  = r_a;
        w_next  = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_data = r_b;
        w_next = S_RUN;
      end
      S_RUN: begin
        if (core_done || w_tc) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Outputs are forced quiet while reset is held, whatever the state.
    if (!rst_n) begin
      w_in_ready = 1'b0;
      w_start    = 1'b0;
      w_data     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_gcd <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b;
            // gcd(x,0) = x, so the bypass result is simply a|b.
            if (w_a_zero || w_b_zero) begin
              r_gcd <= bus.in_a | bus.in_b;
              r_err <= w_a_zero && w_b_zero;
            end
          end
        end
        S_RUN: begin
          // A done arriving on the terminal cycle wins over the timeout.
          if (core_done) begin
            r_gcd <= core_result;
            r_err <= 1'b0;
          end else if (w_tc) begin
            r_gcd <= '0;
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_gcd   = r_gcd;
  assign bus.out_err   = r_err;
  assign core_start    = w_start;
  assign core_data_in  = w_data;
  assign core_rst_n    = rst_n && (r_state != S_CLEAR);

endmodule

`default_nettype wire
